poisson_rate_scheduler: RTL and testbench
=========================================

Name: poisson_rate_scheduler

Overview:
- Time-multiplexed Poisson input source for the LIF array.
- One shared 16-bit Galois LFSR and one comparator serve N_CH channels. Each channel has its own programmable rate register.
- On every frame tick, the block scans all channels, one per clock, and emits a registered spike vector with a one-cycle valid strobe.
- Sits between the host config bus and the neuron array input.

Parameters:
- N_CH, 8, number of spike channels (2..64).
- CH_W, 3, channel index width; must equal clog2(N_CH).
- SEED, 16'hACE1, LFSR reset value; must be non-zero.
- DEFAULT_RATE, 16'd3277, reset value of every rate register (≈5%/frame).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  frame ticks accepted only when high.
- tick  in  1  frame request pulse.
- cfg_we  in  1  rate register write strobe.
- cfg_addr  in  CH_W  channel index for the write.
- cfg_rate  in  16  new rate; spike probability is cfg_rate/65536.
- spike_vec  out  N_CH  spike vector of the last completed frame; bit i = channel i.
- spike_valid  out  1  one-cycle pulse; spike_vec updated this cycle.
- busy  out  1  high during SCAN and EMIT.
- overrun  out  1  sticky: a tick was dropped.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset values: spike_vec=0, spike_valid=0, busy=0, overrun=0, state=IDLE, ch=0, lfsr=SEED, all rate[i]=DEFAULT_RATE.
- Reset asserted mid-frame aborts the frame. No spike_valid is produced.
- LFSR update: lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0). It advances only on SCAN cycles and holds otherwise.
- States:
  - IDLE: if tick && enable, go to SCAN with ch=0 and the shadow vector cleared. If tick && !enable, stay in IDLE; no overrun.
  - SCAN: on each cycle, shadow[ch] = (lfsr < rate[ch]) using the pre-advance lfsr value and the rate register's current value. Then lfsr advances and ch increments. When ch==N_CH-1, go to EMIT.
  - EMIT: spike_vec <= shadow and spike_valid <= 1 for exactly this cycle. Go to IDLE.
- Latency: a tick sampled at edge t gives SCAN cycles t+1..t+N_CH, and spike_valid is high in cycle t+N_CH+1. Minimum tick period for no overrun is N_CH+2 cycles.
- busy = (state != IDLE), registered with the state.
- A tick while busy is dropped and sets overrun, regardless of enable.
- Overrun clear rules:
  - ovr_clr clears overrun on the next edge.
  - If a dropped tick and ovr_clr occur in the same cycle, set wins.
- enable deasserted during SCAN/EMIT: the current frame completes normally. Only new ticks are blocked.
- Rate arithmetic:
  - rate=0 never spikes.
  - rate=0xFFFF spikes unless lfsr==0xFFFF.
  - Comparison is unsigned 16-bit.
- Config writes:
  - A write takes effect on the next edge in any state.
  - A write during SCAN to a channel not yet sampled affects the current frame. A write to a channel already sampled affects the next frame.
  - cfg_addr >= N_CH is ignored.
- spike_vec holds its value between frames.

Optional Feature:
- Macro: POISSON_REFRACTORY_EN.
- Defined: each channel has a 1-frame refractory period. If spike_vec[i] from the previous completed frame is 1, shadow[i] is forced to 0 in the current frame. The LFSR still advances for that slot, so the random stream alignment is unchanged. After reset the previous vector is 0.
- Undefined: no refractory logic. Channels are independent Bernoulli draws every frame.

Test Plan:
- Reset check: rst_n low then high, no tick -> spike_vec=0, spike_valid=0, busy=0, overrun=0 for 20 cycles.
- All rates 0: single tick at cycle 10 -> busy high cycles 11..19, spike_valid high only at cycle 19, spike_vec=8'h00.
- All rates 0xFFFF, SEED=ACE1: tick -> spike_vec matches a bit-exact reference model of the LFSR (expect 8'hFF unless a draw equals 0xFFFF). Repeat 1000 frames with rate=3277 on all channels -> total spikes within 5% ±1% of 8000.
- Overrun: tick, then a second tick 3 cycles later -> overrun=1, only one spike_valid. Then ovr_clr together with a third tick while busy -> overrun remains 1. ovr_clr alone -> overrun 0.
- Config mid-scan: set rate[7]=0xFFFF and write rate[7]=0 during SCAN cycle 2 -> ch7 bit is 0 this frame. Write rate[0]=0 in the same frame -> ch0 is unaffected until the next frame. A write to addr 8 with N_CH=8... (use N_CH=6, addr 7) -> ignored.
- With POISSON_REFRACTORY_EN, all rates 0xFFFF, back-to-back frames -> frame1 vector ≈ all ones, frame2 = 8'h00, frame3 ≈ all ones again.

Source files
------------

// File: rtl/poisson_rate_scheduler.sv
// poisson_rate_scheduler
//
// Time-multiplexed Poisson spike source feeding the LIF array. One shared
// 16-bit Galois LFSR and one comparator serve N_CH channels, each with its
// own programmable rate register. A frame tick starts a scan that visits one
// channel per clock; the finished spike vector is registered and flagged with
// a single-cycle valid strobe.
//
// Optional feature macro: POISSON_REFRACTORY_EN
//   When defined, a channel that spiked in the previous completed frame is
//   held silent for the current frame (the LFSR still advances for its slot).
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   enable       frame ticks accepted only when high
//   tick         frame request pulse
//   cfg_we       rate register write strobe
//   cfg_addr     channel index for the write (>= N_CH ignored)
//   cfg_rate     new rate; spike probability = cfg_rate / 65536
//   spike_vec    spike vector of the last completed frame (bit i = channel i)
//   spike_valid  one-cycle pulse when spike_vec has just been updated
//   busy         high while scanning or emitting
//   overrun      sticky flag: a tick arrived while busy and was dropped
//   ovr_clr      clears overrun (a simultaneous dropped tick wins)

module poisson_rate_scheduler #(
    parameter int          N_CH         = 8,
    parameter int          CH_W         = 3,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic [15:0] DEFAULT_RATE = 16'd3277
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            tick,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_addr,
    input  logic [15:0]     cfg_rate,
    output logic [N_CH-1:0] spike_vec,
    output logic            spike_valid,
    output logic            busy,
    output logic            overrun,
    input  logic            ovr_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CH_W-1:0] ch;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [15:0]     rate [N_CH];
    logic [N_CH-1:0] shadow;
    logic [N_CH-1:0] shadow_next;
    logic            draw;
    logic            last_ch;
    logic            tick_start;
    logic            tick_drop;
    logic            addr_ok;

    assign last_ch    = (ch == CH_W'(N_CH - 1));
    assign tick_start = tick && enable && (state == IDLE);
    assign tick_drop  = tick && (state != IDLE);
    assign addr_ok    = ({1'b0, cfg_addr} < (CH_W + 1)'(N_CH));

    // Right-shifting Galois LFSR, taps 0xB400 (maximal length, never reaches 0).
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Bernoulli draw for the channel being visited, using the pre-advance LFSR
    // value. Under the refractory option the previous frame's output (still in
    // spike_vec) masks the draw.
    always_comb begin
        draw = (lfsr < rate[ch]);
`ifdef POISSON_REFRACTORY_EN
        if (spike_vec[ch]) begin
            draw = 1'b0;
        end
`endif
        shadow_next     = shadow;
        shadow_next[ch] = draw;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick && enable) state_next = SCAN;
            SCAN:    if (last_ch)        state_next = EMIT;
            EMIT:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // State register; busy is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Scan datapath. The output vector and valid strobe are loaded on the edge
    // that leaves the last SCAN cycle, so they are visible during the EMIT
    // cycle itself; the strobe self-clears on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch          <= '0;
            lfsr        <= SEED;
            shadow      <= '0;
            spike_vec   <= '0;
            spike_valid <= 1'b0;
        end else begin
            spike_valid <= 1'b0;
            if (tick_start) begin
                ch     <= '0;
                shadow <= '0;
            end else if (state == SCAN) begin
                shadow <= shadow_next;
                lfsr   <= lfsr_next;
                if (last_ch) begin
                    ch          <= '0;
                    spike_vec   <= shadow_next;
                    spike_valid <= 1'b1;
                end else begin
                    ch <= ch + CH_W'(1);
                end
            end
        end
    end

    // Sticky overrun flag; a dropped tick takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (tick_drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    // Rate registers. Writes land on the next edge in any state, so a write
    // during a scan reaches only the channels not yet visited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                rate[i] <= DEFAULT_RATE;
            end
        end else if (cfg_we && addr_ok) begin
            rate[cfg_addr] <= cfg_rate;
        end
    end

endmodule

// File: tb/tb_poisson_rate_scheduler.sv
// tb_poisson_rate_scheduler
//
// Directed bench for poisson_rate_scheduler. An 8-channel instance covers
// reset, latency, rate extremes, overrun, mid-scan config writes and the
// long-run spike density; a 6-channel instance covers ignored writes to
// out-of-range addresses. Expected spike vectors come from a bit-exact model
// of the shared LFSR and the rate registers kept inside the bench.

module tb_poisson_rate_scheduler;

    localparam int N_CH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_rate = '0;
    logic        ovr_clr = 1'b0;
    logic [7:0]  spike_vec;
    logic        spike_valid;
    logic        busy;
    logic        overrun;

    logic        tick6 = 1'b0;
    logic        cfg_we6 = 1'b0;
    logic [2:0]  cfg_addr6 = '0;
    logic [15:0] cfg_rate6 = '0;
    logic [5:0]  spike_vec6;
    logic        spike_valid6;
    logic        busy6;
    logic        overrun6;

    int vectors = 0;
    int miscompares = 0;

    // Bench-side model state.
    logic [15:0] m_lfsr;
    logic [15:0] m_rate [N_CH];
    logic [7:0]  m_prev;

    poisson_rate_scheduler #(.N_CH(8), .CH_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_rate(cfg_rate),
        .spike_vec(spike_vec), .spike_valid(spike_valid), .busy(busy),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    poisson_rate_scheduler #(.N_CH(6), .CH_W(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick6),
        .cfg_we(cfg_we6), .cfg_addr(cfg_addr6), .cfg_rate(cfg_rate6),
        .spike_vec(spike_vec6), .spike_valid(spike_valid6), .busy(busy6),
        .overrun(overrun6), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock: wait for the rising edge, then settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Single-cycle rate write on the 8-channel instance, mirrored into the model.
    task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] rate);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_rate = rate;
        step();
        cfg_we   = 1'b0;
        m_rate[addr] = rate;
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic modelReset();
        m_lfsr = 16'hACE1;
        m_prev = '0;
        for (int i = 0; i < N_CH; i++) m_rate[i] = 16'd3277;
    endtask

    // Expected vector of the next frame, advancing the model LFSR.
    task automatic modelFrame(output logic [7:0] v);
        v = '0;
        for (int i = 0; i < N_CH; i++) begin
            v[i] = (m_lfsr < m_rate[i]);
`ifdef POISSON_REFRACTORY_EN
            if (m_prev[i]) v[i] = 1'b0;
`endif
            m_lfsr = lfsrStep(m_lfsr);
        end
        m_prev = v;
    endtask

    // Waits for the strobe (n0 cycles already spent after the tick edge),
    // then checks latency, the vector, and the return to idle.
    task automatic finishFrame(input logic [7:0] exp_vec, input string tag, input int n0);
        int n;
        n = n0;
        while (!spike_valid && n < 40) begin
            step();
            n++;
        end
        checkOutput({tag, "_latency"}, n, N_CH);
        checkOutput({tag, "_vec"}, {24'd0, spike_vec}, {24'd0, exp_vec});
        step();
        checkOutput({tag, "_idle"}, {30'd0, spike_valid, busy}, 32'd0);
    endtask

    task automatic runFrame(input logic [7:0] exp_vec, input string tag);
        tick = 1'b1;
        step();
        tick = 1'b0;
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        finishFrame(exp_vec, tag, 0);
    endtask

    // Quiet frame used by the long statistics run.
    task automatic fastFrame(output logic [7:0] v, output bit ok);
        int n;
        n = 0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        while (!spike_valid && n < 40) begin
            step();
            n++;
        end
        v  = spike_vec;
        ok = (n == N_CH);
        step();
    endtask

    initial begin
        logic [7:0] exp_v;
        logic [7:0] got_v;
        bit         ok;
        int         cnt;
        int         dut_total;
        int         mod_total;
        int         bad_frames;

        modelReset();

        // Reset state held for 20 cycles with no tick.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("reset_c%0d", c),
                        {21'd0, spike_vec, spike_valid, busy, overrun}, 32'd0);
            step();
        end

        // Reset in the middle of a scan aborts the frame with no strobe.
        enable = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (spike_valid) cnt++;
            step();
        end
        checkOutput("abort_no_valid", cnt, 0);
        modelReset();

        // Tick while disabled in IDLE is ignored and is not an overrun.
        enable = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        checkOutput("disabled_tick", {30'd0, busy, overrun}, 32'd0);
        enable = 1'b1;

        // Long run on reset-default rates (3277 = ~5%).
        dut_total  = 0;
        mod_total  = 0;
        bad_frames = 0;
        for (int f = 0; f < 1000; f++) begin
            modelFrame(exp_v);
            fastFrame(got_v, ok);
            if (!ok || got_v !== exp_v) bad_frames++;
            dut_total += $countones(got_v);
            mod_total += $countones(exp_v);
        end
        checkOutput("stat_bad_frames", bad_frames, 0);
        checkOutput("stat_total", dut_total, mod_total);
        checkOutput("stat_range", {31'd0, (dut_total >= 320 && dut_total <= 480)}, 32'd1);

        // All rates zero: never spikes.
        for (int i = 0; i < N_CH; i++) applyStimulus(3'(i), 16'h0000);
        modelFrame(exp_v);
        runFrame(8'h00, "rate0");

        // All rates 0xFFFF, three back-to-back frames.
        for (int i = 0; i < N_CH; i++) applyStimulus(3'(i), 16'hFFFF);
        for (int f = 0; f < 3; f++) begin
            modelFrame(exp_v);
            runFrame(exp_v, $sformatf("rateFFFF_f%0d", f));
        end

        // Overrun: a tick 3 cycles into the scan is dropped even with enable low;
        // a clear coinciding with a dropped tick loses.
        modelFrame(exp_v);
        tick = 1'b1;
        step();
        tick = 1'b0;
        enable = 1'b0;
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        checkOutput("ovr_set", {30'd0, overrun, busy}, 32'd3);
        enable = 1'b1;
        tick = 1'b1;
        ovr_clr = 1'b1;
        step();
        tick = 1'b0;
        ovr_clr = 1'b0;
        checkOutput("ovr_set_wins", {31'd0, overrun}, 32'd1);
        cnt = 0;
        got_v = '0;
        for (int c = 0; c < 12; c++) begin
            if (spike_valid) begin
                cnt++;
                got_v = spike_vec;
            end
            step();
        end
        checkOutput("ovr_one_valid", cnt, 1);
        checkOutput("ovr_vec", {24'd0, got_v}, {24'd0, exp_v});
        checkOutput("ovr_idle", {31'd0, busy}, 32'd0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        checkOutput("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Mid-scan writes: rate[7] changed before ch7 is visited affects this
        // frame; rate[0] changed after ch0 is visited affects only the next.
        for (int i = 0; i < N_CH; i++) applyStimulus(3'(i), 16'hFFFF);
        m_rate[7] = 16'h0000;
        modelFrame(exp_v);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        cfg_we = 1'b1;
        cfg_addr = 3'd7;
        cfg_rate = 16'h0000;
        step();
        cfg_addr = 3'd0;
        step();
        cfg_we = 1'b0;
        finishFrame(exp_v, "midscan_f0", 3);
        checkOutput("midscan_ch7_low", {31'd0, spike_vec[7]}, 32'd0);
        m_rate[0] = 16'h0000;
        modelFrame(exp_v);
        runFrame(exp_v, "midscan_f1");

        // Six-channel instance: writes to addresses 6 and 7 are ignored.
        for (int i = 0; i < 8; i++) begin
            cfg_we6   = 1'b1;
            cfg_addr6 = 3'(i);
            cfg_rate6 = (i < 6) ? 16'h0000 : 16'hFFFF;
            step();
        end
        cfg_we6 = 1'b0;
        tick6 = 1'b1;
        step();
        tick6 = 1'b0;
        cnt = 0;
        while (!spike_valid6 && cnt < 40) begin
            step();
            cnt++;
        end
        checkOutput("n6_latency", cnt, 6);
        checkOutput("n6_vec", {26'd0, spike_vec6}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
